// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared encodings, FSM states and latency defaults for the multiply/divide unit.
`default_nettype none

package md_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam int MD_MUL_CYCLES_DEFAULT = 5;
  localparam int MD_DIV_CYCLES_DEFAULT = 10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  typedef struct packed {
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

endpackage

`default_nettype wire

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with fixed-latency MULT/MULTU/DIV/DIVU and MTHI/MTLO.
// Result is computed at launch and committed to HI/LO when the latency counter expires.
`default_nettype none

module md_unit
  import md_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MD_MUL_CYCLES_DEFAULT,
  parameter int DIV_CYCLES = MD_DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t        state, state_next;
  logic [CNT_W-1:0] count, count_next;
  md_result_t       pending, result;
  logic             commit;
  logic             accept;
  logic             mt_ok;
  logic             is_div;
  logic             is_signed;

  function automatic md_result_t md_mul(input logic [31:0] x, input logic [31:0] y,
                                        input logic sgn);
    logic [63:0] xe, ye, p;
    md_result_t  r;
    xe = sgn ? {{32{x[31]}}, x} : {32'b0, x};
    ye = sgn ? {{32{y[31]}}, y} : {32'b0, y};
    p  = xe * ye;
    r.div_zero = 1'b0;
    r.hi       = p[63:32];
    r.lo       = p[31:0];
    return r;
  endfunction

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps naturally instead of trapping.
  function automatic md_result_t md_div(input logic [31:0] x, input logic [31:0] y,
                                        input logic sgn);
    logic        neg_q, neg_r;
    logic [31:0] ux, uy, q, rm;
    md_result_t  r;
    neg_r = sgn & x[31];
    neg_q = sgn & (x[31] ^ y[31]);
    ux    = neg_r ? (~x + 32'd1) : x;
    uy    = (sgn & y[31]) ? (~y + 32'd1) : y;
    if (uy == 32'd0) begin
      q  = 32'd0;
      rm = 32'd0;
      r.div_zero = 1'b1;
    end else begin
      q  = ux / uy;
      rm = ux % uy;
      r.div_zero = 1'b0;
    end
    r.lo = neg_q ? (~q + 32'd1) : q;
    r.hi = neg_r ? (~rm + 32'd1) : rm;
    return r;
  endfunction

  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign result    = is_div ? md_div(a, b, is_signed) : md_mul(a, b, is_signed);
  assign accept    = (state == IDLE) && start;
  assign mt_ok     = (state == IDLE) && !start;

  always_comb begin
    state_next = state;
    count_next = count;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          count_next = is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      RUN: begin
        count_next = count - CNT_ONE;
        if (count == CNT_ONE) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      busy  <= (state_next == RUN);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else if (accept) begin
      pending <= result;
    end
  end

  // A zero divisor still runs the full latency but leaves HI/LO untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (commit) begin
      if (!pending.div_zero) begin
        hi <= pending.hi;
        lo <= pending.lo;
      end
    end else if (mt_ok) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit with hand-computed HI/LO and busy lengths.
`default_nettype none

module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        hi_we, lo_we;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Returns at the first negedge after the accepting edge (busy cycle 1).
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want %h", hi, 32'd0); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want %h", lo, 32'd0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mthi_hi: got %h want %h", hi, 32'h12345678); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL mthi_lo: got %h want %h", lo, 32'd0); end
  endtask

  task automatic test_mult;
    int n;
    launch(MD_MULT, 32'hFFFFFFFE, 32'd3);
    total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mult_hold_hi: got %h want %h", hi, 32'h12345678); end
    wait_idle(n);
    total++; if (n != 5) begin bad++; $display("FAIL mult_busy_len: got %0d want 5", n); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi: got %h want %h", hi, 32'hFFFFFFFF); end
    total++; if (lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo: got %h want %h", lo, 32'hFFFFFFFA); end
    launch(MD_MULTU, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    total++; if (n != 5) begin bad++; $display("FAIL multu_busy_len: got %0d want 5", n); end
    total++; if (hi !== 32'h00000002) begin bad++; $display("FAIL multu_hi: got %h want %h", hi, 32'h2); end
    total++; if (lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL multu_lo: got %h want %h", lo, 32'hFFFFFFFA); end
  endtask

  task automatic test_div;
    int n;
    launch(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    total++; if (n != 10) begin bad++; $display("FAIL div_busy_len: got %0d want 10", n); end
    total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo: got %h want %h", lo, 32'hFFFFFFFD); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi: got %h want %h", hi, 32'hFFFFFFFF); end
    launch(MD_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    total++; if (n != 10) begin bad++; $display("FAIL divu_busy_len: got %0d want 10", n); end
    total++; if (lo !== 32'd3) begin bad++; $display("FAIL divu_lo: got %h want %h", lo, 32'd3); end
    total++; if (hi !== 32'd1) begin bad++; $display("FAIL divu_hi: got %h want %h", hi, 32'd1); end
  endtask

  task automatic test_div_zero;
    int n;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11111111;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    total++; if (hi !== 32'h11111111) begin bad++; $display("FAIL mt_both_hi: got %h want %h", hi, 32'h11111111); end
    total++; if (lo !== 32'h11111111) begin bad++; $display("FAIL mt_both_lo: got %h want %h", lo, 32'h11111111); end
    hi_we = 1'b1; wdata = 32'hAAAA0000;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000BBBB;
    @(negedge clk);
    lo_we = 1'b0;
    launch(MD_DIVU, 32'd5, 32'd0);
    wait_idle(n);
    total++; if (n != 10) begin bad++; $display("FAIL dz_busy_len: got %0d want 10", n); end
    total++; if (hi !== 32'hAAAA0000) begin bad++; $display("FAIL dz_hi: got %h want %h", hi, 32'hAAAA0000); end
    total++; if (lo !== 32'h0000BBBB) begin bad++; $display("FAIL dz_lo: got %h want %h", lo, 32'h0000BBBB); end
    launch(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    total++; if (n != 10) begin bad++; $display("FAIL ovf_busy_len: got %0d want 10", n); end
    total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL ovf_lo: got %h want %h", lo, 32'h80000000); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL ovf_hi: got %h want %h", hi, 32'd0); end
  endtask

  task automatic test_ignored;
    int n;
    launch(MD_MULT, 32'h00010000, 32'h00010000);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy_on: got %b want 1", busy); end
    start = 1'b1; op = MD_DIV; a = 32'd9; b = 32'd3; lo_we = 1'b1; wdata = 32'h0000DEAD;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL ign_lo_busy: got %h want %h", lo, 32'h80000000); end
    wait_idle(n);
    total++; if (n + 1 != 5) begin bad++; $display("FAIL ign_busy_len: got %0d want 5", n + 1); end
    total++; if (hi !== 32'h00000001) begin bad++; $display("FAIL ign_hi: got %h want %h", hi, 32'h1); end
    total++; if (lo !== 32'h00000000) begin bad++; $display("FAIL ign_lo: got %h want %h", lo, 32'h0); end
    // start and hi_we together: only the multiply acts
    @(negedge clk);
    start = 1'b1; op = MD_MULTU; a = 32'd2; b = 32'd3; hi_we = 1'b1; wdata = 32'h00005555;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    total++; if (hi !== 32'h00000001) begin bad++; $display("FAIL prio_hi_busy: got %h want %h", hi, 32'h1); end
    wait_idle(n);
    total++; if (n != 5) begin bad++; $display("FAIL prio_busy_len: got %0d want 5", n); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL prio_hi: got %h want %h", hi, 32'd0); end
    total++; if (lo !== 32'd6) begin bad++; $display("FAIL prio_lo: got %h want %h", lo, 32'd6); end
  endtask

  task automatic test_reset_mid;
    int n;
    launch(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL rmid_hi: got %h want %h", hi, 32'd0); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL rmid_lo: got %h want %h", lo, 32'd0); end
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rpost_busy: got %b want 0", busy); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL rpost_hi: got %h want %h", hi, 32'd0); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL rpost_lo: got %h want %h", lo, 32'd0); end
    launch(MD_MULT, 32'd6, 32'd7);
    wait_idle(n);
    total++; if (n != 5) begin bad++; $display("FAIL fresh_busy_len: got %0d want 5", n); end
    total++; if (lo !== 32'd42) begin bad++; $display("FAIL fresh_lo: got %h want %h", lo, 32'd42); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL fresh_hi: got %h want %h", hi, 32'd0); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
